puf_eval_ctrl: RTL and testbench

PUF_EVAL_CTRL -- requirements
Module: puf_eval_ctrl

---
 rtl/puf_pkg.sv | 17 +
 rtl/puf_resp_sync.sv | 24 ++
 rtl/puf_eval_ctrl.sv | 141 ++++++++++++++
 tb/tb_puf_eval_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared FSM state type and default build constants for the PUF evaluation controller.
package puf_pkg;

  localparam int PUF_CHAL_W     = 64;
  localparam int PUF_DISCH_CYC  = 4;
  localparam int PUF_SETTLE_CYC = 16;
  localparam int PUF_REPS       = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_FIRE   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } puf_state_e;

endpackage

// File: rtl/puf_resp_sync.sv
// Two-flop synchronizer bringing the raw asynchronous PUF race result into clk.
module puf_resp_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF evaluation sequencer: discharge, fire, sample, repeated with a majority vote.
// Majority voting over REPS evaluations needs PUF_MAJORITY_VOTE_EN; otherwise one evaluation.
//   state  | meaning
//   IDLE   | chal_ready high, waiting for a challenge
//   ARM    | excite low, race paths discharging
//   FIRE   | exciteL/exciteR high, race settling through the synchronizer
//   SAMPLE | synchronized response added to the ones count
//   DONE   | resp_valid high until resp_ready
module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int CHAL_W     = PUF_CHAL_W,
  parameter int DISCH_CYC  = PUF_DISCH_CYC,
  parameter int SETTLE_CYC = PUF_SETTLE_CYC,
  parameter int REPS       = PUF_REPS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      chal_valid,
  output logic                      chal_ready,
  input  logic [CHAL_W-1:0]         chal_in,
  output logic [CHAL_W-1:0]         challenge,
  output logic                      exciteL,
  output logic                      exciteR,
  input  logic                      puf_resp,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic                      resp,
  output logic [$clog2(REPS+1)-1:0] resp_ones
);

`ifdef PUF_MAJORITY_VOTE_EN
  localparam int EFF_REPS = REPS;
`else
  localparam int EFF_REPS = 1;
`endif

  localparam int CNT_W   = $clog2(REPS + 1);
  localparam int TMR_MAX = (DISCH_CYC > SETTLE_CYC) ? DISCH_CYC : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  puf_state_e        state_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [CNT_W-1:0]  rep_q;
  logic [CNT_W-1:0]  ones_q;
  logic [CHAL_W-1:0] chal_q;
  logic              excite_q;
  logic              chal_ready_q;
  logic              resp_valid_q;
  logic              resp_q;
  logic              sync_resp;
  logic [CNT_W-1:0]  rep_d;
  logic [CNT_W-1:0]  ones_d;

  puf_resp_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (puf_resp),
    .sync_o  (sync_resp)
  );

  always_comb begin
    rep_d  = (rep_q == CNT_W'(EFF_REPS)) ? rep_q : rep_q + 1'b1;
    ones_d = ones_q + CNT_W'(sync_resp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      rep_q        <= '0;
      ones_q       <= '0;
      chal_q       <= '0;
      excite_q     <= 1'b0;
      chal_ready_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          chal_ready_q <= 1'b1;
          if (chal_valid && chal_ready_q) begin
            chal_q       <= chal_in;
            rep_q        <= '0;
            ones_q       <= '0;
            chal_ready_q <= 1'b0;
            // First discharge also covers the accept cycle, so every rise sees DISCH_CYC+1 low cycles
            tmr_q        <= TMR_W'(DISCH_CYC);
            state_q      <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (tmr_q == '0) begin
            excite_q <= 1'b1;
            tmr_q    <= TMR_W'(SETTLE_CYC - 1);
            state_q  <= ST_FIRE;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        ST_FIRE: begin
          if (tmr_q == '0) begin
            excite_q <= 1'b0;
            state_q  <= ST_SAMPLE;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        ST_SAMPLE: begin
          rep_q  <= rep_d;
          ones_q <= ones_d;
          if (rep_d == CNT_W'(EFF_REPS)) begin
            resp_q       <= (ones_d > CNT_W'(EFF_REPS / 2));
            resp_valid_q <= 1'b1;
            state_q      <= ST_DONE;
          end else begin
            tmr_q   <= TMR_W'(DISCH_CYC - 1);
            state_q <= ST_ARM;
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            chal_ready_q <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign chal_ready = chal_ready_q;
  assign challenge  = chal_q;
  assign exciteL    = excite_q;
  assign exciteR    = excite_q;
  assign resp_valid = resp_valid_q;
  assign resp       = resp_q;
  assign resp_ones  = ones_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Scoreboard bench for puf_eval_ctrl; follows PUF_MAJORITY_VOTE_EN like the design.
module tb_puf_eval_ctrl;

  localparam int CW = 64;
  localparam int D  = 4;
  localparam int S  = 16;
  localparam int R  = 5;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int ER = R;
`else
  localparam int ER = 1;
`endif
  localparam int LAT = 1 + ER * (D + S + 1);
  localparam int OW  = $clog2(R + 1);

  typedef struct {
    logic [CW-1:0] chal;
    logic          resp;
    int            ones;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          chal_valid, chal_ready, resp_valid, resp_ready, resp;
  logic          exciteL, exciteR, puf_resp;
  logic [CW-1:0] chal_in, challenge;
  logic [OW-1:0] resp_ones;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   rv_rises = 0;
  exp_t q[$];

  puf_eval_ctrl #(.CHAL_W(CW), .DISCH_CYC(D), .SETTLE_CYC(S), .REPS(R)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .chal_valid (chal_valid),
    .chal_ready (chal_ready),
    .chal_in    (chal_in),
    .challenge  (challenge),
    .exciteL    (exciteL),
    .exciteR    (exciteR),
    .puf_resp   (puf_resp),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp       (resp),
    .resp_ones  (resp_ones)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got no event within the cycle bound, expected one", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic       rv_prev = 1'b0, ex_prev = 1'b0;
  logic       rsp_ref;
  logic [OW-1:0] ones_ref;
  bit         inflight = 0, chal_bad = 0, lr_bad = 0, stable_bad = 0;
  bit         hs_pending = 0, have_hs = 0, valid_held = 0;
  int         last_acc = 0, hs_cyc = 0, ex_rise = 0, ex_fall = 0, pulses = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rv_prev = 1'b0; ex_prev = 1'b0; inflight = 0; pulses = 0;
      hs_pending = 0; have_hs = 0; valid_held = 0;
    end else begin
      if (hs_pending) begin
        chk("after_hs.resp_valid", 64'(resp_valid), 64'd0);
        chk("after_hs.chal_ready", 64'(chal_ready), 64'd1);
        hs_pending = 0;
      end
      if (exciteL !== exciteR) lr_bad = 1;
      if (exciteL === 1'b1 && !ex_prev) begin
        if (pulses == 0) chk("first_rise_after_accept", 64'(cyc - last_acc), 64'(D + 1));
        else             chk("low_before_rise", 64'(cyc - ex_fall), 64'(D + 1));
        ex_rise = cyc;
        pulses++;
      end
      if (exciteL === 1'b0 && ex_prev) begin
        chk("excite_high_len", 64'(cyc - ex_rise), 64'(S));
        ex_fall = cyc;
      end
      ex_prev = (exciteL === 1'b1);
      if (inflight && (q.size() == 0 || challenge !== q[0].chal)) chal_bad = 1;
      if (resp_valid === 1'b1 && !rv_prev) begin
        rv_rises++;
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_resp_valid: got 1, expected 0 (no challenge outstanding)");
        end else begin
          chk("latency", 64'(cyc - last_acc), 64'(LAT));
          chk("resp", 64'(resp), 64'(q[0].resp));
          chk("resp_ones", 64'(resp_ones), 64'(q[0].ones));
          chk("pulse_count", 64'(pulses), 64'(ER));
          chk("challenge_held", 64'(chal_bad), 64'd0);
          chk("excite_lr_same", 64'(lr_bad), 64'd0);
        end
        rsp_ref = resp;
        ones_ref = resp_ones;
        stable_bad = 0;
      end
      if (resp_valid === 1'b1) begin
        if (resp !== rsp_ref || resp_ones !== ones_ref || chal_ready !== 1'b0) stable_bad = 1;
        if (resp_ready === 1'b1) begin
          chk("done_stable", 64'(stable_bad), 64'd0);
          if (q.size() > 0) void'(q.pop_front());
          inflight = 0;
          hs_pending = 1;
          hs_cyc = cyc + 1;
          have_hs = 1;
          valid_held = (chal_valid === 1'b1);
        end
      end
      rv_prev = (resp_valid === 1'b1);
      if (chal_valid === 1'b1 && chal_ready === 1'b1) begin
        if (have_hs && valid_held) chk("accept_after_hs", 64'(cyc + 1 - hs_cyc), 64'd1);
        have_hs = 0;
        last_acc = cyc + 1;
        inflight = 1;
        pulses = 0;
        chal_bad = 0;
        lr_bad = 0;
      end
      if (chal_valid !== 1'b1) valid_held = 0;
    end
  end

  // ---------------- stimulus ----------------
  function automatic exp_t model(input logic [CW-1:0] c, input logic [7:0] bits);
    exp_t e;
    e.chal = c;
    e.ones = 0;
    for (int k = 0; k < ER; k++) e.ones += int'(bits[k]);
    e.resp = (e.ones > ER / 2);
    return e;
  endfunction

  task automatic wait_excite(input logic level, output bit ok);
    int n = 0;
    while (exciteL !== level && n < 100) begin tick(); n++; end
    ok = (exciteL === level);
  endtask

  task automatic run_chal(input logic [CW-1:0] c, input logic [7:0] bits, input int delay,
                          input bit keep_valid);
    int n = 0;
    bit ok;
    chal_in = c;
    chal_valid = 1'b1;
    while (chal_ready !== 1'b1 && n < 300) begin tick(); n++; end
    if (chal_ready !== 1'b1) begin timeout("accept_wait"); chal_valid = 1'b0; return; end
    q.push_back(model(c, bits));
    tick();
    if (keep_valid) chal_in = {$urandom, $urandom};
    else chal_valid = 1'b0;
    for (int k = 0; k < ER; k++) begin
      wait_excite(1'b1, ok);
      if (!ok) begin timeout("excite_rise_wait"); return; end
      puf_resp = bits[k];
      wait_excite(1'b0, ok);
      if (!ok) begin timeout("excite_fall_wait"); return; end
    end
    n = 0;
    while (resp_valid !== 1'b1 && n < 100) begin tick(); n++; end
    if (resp_valid !== 1'b1) begin timeout("resp_valid_wait"); return; end
    repeat (delay) tick();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic reset_mid_fire();
    int n = 0;
    int saved;
    bit ok;
    int target = (ER >= 3) ? 3 : ER;
    chal_in = {$urandom, $urandom};
    chal_valid = 1'b1;
    while (chal_ready !== 1'b1 && n < 300) begin tick(); n++; end
    if (chal_ready !== 1'b1) begin timeout("rst_accept_wait"); chal_valid = 1'b0; return; end
    q.push_back(model(chal_in, 8'hFF));
    tick();
    chal_valid = 1'b0;
    for (int p = 0; p < target; p++) begin
      wait_excite(1'b1, ok);
      if (!ok) begin timeout("rst_fire_wait"); return; end
      if (p < target - 1) begin
        wait_excite(1'b0, ok);
        if (!ok) begin timeout("rst_fire_fall_wait"); return; end
      end
    end
    repeat (3) tick();
    chk("fire_before_rst.exciteL", 64'(exciteL), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async.exciteL", 64'(exciteL), 64'd0);
    chk("rst_async.exciteR", 64'(exciteR), 64'd0);
    chk("rst_async.resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_async.challenge", challenge, 64'd0);
    chk("rst_async.resp_ones", 64'(resp_ones), 64'd0);
    q.delete();
    @(posedge clk);
    #3;
    chk("rst_release.chal_ready_before_edge", 64'(chal_ready), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_release.chal_ready_first_edge", 64'(chal_ready), 64'd1);
    saved = rv_rises;
    repeat (LAT + 10) tick();
    chk("no_partial_resp", 64'(rv_rises - saved), 64'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    chal_valid = 1'b0;
    resp_ready = 1'b0;
    puf_resp = 1'b0;
    chal_in = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset.chal_ready", 64'(chal_ready), 64'd0);
    chk("reset.resp_valid", 64'(resp_valid), 64'd0);
    chk("reset.resp", 64'(resp), 64'd0);
    chk("reset.resp_ones", 64'(resp_ones), 64'd0);
    chk("reset.challenge", challenge, 64'd0);
    chk("reset.excite", 64'({exciteL, exciteR}), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("reset.chal_ready_first_edge", 64'(chal_ready), 64'd1);

    run_chal(64'h05050F0F05050F0F, 8'hFF, 0, 0);
    run_chal({$urandom, $urandom}, 8'b0000_0101, 2, 0);
    run_chal({$urandom, $urandom}, 8'h00, 1, 0);
    for (int i = 0; i < 8; i++)
      run_chal({$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3), 0);
    run_chal({$urandom, $urandom}, 8'($urandom), 10, 1);
    run_chal({$urandom, $urandom}, 8'($urandom), 0, 0);
    reset_mid_fire();
    run_chal({$urandom, $urandom}, 8'hFF, 1, 0);

    repeat (5) tick();
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
